// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: program-memory read port, instruction-issue handshake and jump redirect.
// The master side is the fetch unit; the slave side is the memory plus execute core.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic               jmp_req;
    logic [ADDR_W-1:0]  jmp_target;

    modport master (
        output imem_rd_en, imem_addr, ir_out, ir_valid,
        input  imem_rdata, ir_ready, jmp_req, jmp_target
    );

    modport slave (
        input  imem_rd_en, imem_addr, ir_out, ir_valid,
        output imem_rdata, ir_ready, jmp_req, jmp_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: owns the PC, reads program memory, issues words to the core.
// Build option: define IFU_PC_WRAP_EN to let the sequential PC wrap from the last address to 0.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [4:0]        HLT_OP   = 5'b11111,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    instr_fetch_unit_if.master  bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted,
    output logic                pc_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } state_t;

`ifndef IFU_PC_WRAP_EN
    localparam logic [ADDR_W-1:0] PC_MAX = '1;
`endif

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic               pc_err_q, pc_err_d;
    logic               handshake;
    logic               is_hlt;

    assign handshake = ir_valid_q & bus.ir_ready;
    assign is_hlt    = (bus.imem_rdata[INSTR_W-1 -: 5] == HLT_OP);

    always_comb begin
        // NOTE: every next-value signal gets its hold value first, so no branch can leave
        // one unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_err_d   = pc_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // A halt word is never issued; pc keeps pointing at it.
                if (is_hlt) begin
                    state_d = HALT;
                end else begin
                    ir_d       = bus.imem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    ir_valid_d = 1'b0;
                    if (bus.jmp_req) begin
                        pc_d    = bus.jmp_target;
                        state_d = FETCH;
                    end
`ifdef IFU_PC_WRAP_EN
                    else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
`else
                    else if (pc_q == PC_MAX) begin
                        pc_err_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
`endif
                end
            end
            HALT: begin
                if (start) begin
                    pc_d     = START_PC;
                    pc_err_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values,
        // independent of statement order.
        if (sys_rst) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_err_q   <= pc_err_d;
        end
    end

    assign bus.imem_rd_en = (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.ir_out     = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign pc             = pc_q;
    assign busy           = (state_q == FETCH) || (state_q == WAIT) || (state_q == ISSUE);
    assign halted         = (state_q == HALT);
    assign pc_err         = pc_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven issue/jump/backpressure run plus hand-written
// sequences for start timing, end of memory, mid-operation reset and restart.
module tb_instr_fetch_unit;
    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic [AW-1:0] pc1, pc2;
    logic          busy1, halted1, err1;
    logic          busy2, halted2, err2;
    logic [IW-1:0] mem [256];

    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) b1 ();
    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) b2 ();

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .START_PC(8'h00)) u_dut (
        .clk(clk), .sys_rst(sys_rst), .start(start1), .bus(b1.master),
        .pc(pc1), .busy(busy1), .halted(halted1), .pc_err(err1)
    );

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .START_PC(8'hFF)) u_dut_end (
        .clk(clk), .sys_rst(sys_rst), .start(start2), .bus(b2.master),
        .pc(pc2), .busy(busy2), .halted(halted2), .pc_err(err2)
    );

    initial forever #5 clk = ~clk;

    // Synchronous program memory shared by both instances.
    always @(posedge clk) begin
        if (b1.imem_rd_en) b1.imem_rdata <= mem[b1.imem_addr];
        if (b2.imem_rd_en) b2.imem_rdata <= mem[b2.imem_addr];
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [IW-1:0] sb [$];

    typedef struct {
        logic [IW-1:0] word;
        int            stall;
        logic          jmp;
        logic [AW-1:0] target;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [IW-1:0] mk_instr(input logic [4:0] op, input logic [4:0] rdst,
                                               input logic [4:0] rs1, input logic imm,
                                               input logic [15:0] isrc);
        return {op, rdst, rs1, imm, isrc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Scoreboard compare at the negedge, then advance to just after the next rising edge.
    task automatic tick();
        logic [IW-1:0] exp_w;
        @(negedge clk);
        if (b1.ir_valid && b1.ir_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_issue: got %0h with no expected word queued", b1.ir_out);
            end else begin
                exp_w = sb.pop_front();
                check("sb_issue", b1.ir_out, exp_w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] adi, movi, hlt, w_end;
    logic [AW-1:0] exp_pc;

    initial begin
        adi   = mk_instr(5'd2, 5'd0, 5'd2, 1'b1, 16'd4);
        movi  = mk_instr(5'd13, 5'd4, 5'd0, 1'b1, 16'd55);
        hlt   = {5'b11111, 27'd0};
        w_end = mk_instr(5'd3, 5'd1, 5'd1, 1'b0, 16'h0800);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]   = adi;
        mem[1]   = movi;
        mem[2]   = hlt;
        mem[255] = w_end;

        vecs[0] = '{adi,  0, 1'b0, 8'h00};
        vecs[1] = '{movi, 4, 1'b1, 8'h40};
        vecs[2] = '{mk_instr(5'd4, 5'd1, 5'd2, 1'b0, 16'h3000), 1, 1'b0, 8'h00};
        vecs[3] = '{mk_instr(5'd6, 5'd3, 5'd7, 1'b1, 16'h1234), 2, 1'b1, 8'h10};
        vecs[4] = '{mk_instr(5'd1, 5'd2, 5'd5, 1'b0, 16'h0042), 0, 1'b0, 8'h00};

        b1.ir_ready = 1'b0; b1.jmp_req = 1'b0; b1.jmp_target = '0;
        b2.ir_ready = 1'b1; b2.jmp_req = 1'b0; b2.jmp_target = '0;

        // Reset state.
        repeat (3) tick();
        sys_rst = 1'b0;
        check("rst_pc", pc1, 8'h00);
        check("rst_busy", busy1, 1'b0);
        check("rst_halted", halted1, 1'b0);
        check("rst_pc_err", err1, 1'b0);
        check("rst_ir_valid", b1.ir_valid, 1'b0);
        check("rst_ir_out", b1.ir_out, 32'h0);
        check("rst_rd_en", b1.imem_rd_en, 1'b0);
        check("rst_pc_end", pc2, 8'hFF);

        // End of memory on the START_PC=FF instance.
        start2 = 1'b1; tick(); start2 = 1'b0;
        check("end_fetch_en", b2.imem_rd_en, 1'b1);
        check("end_fetch_addr", b2.imem_addr, 8'hFF);
        tick(); tick();
        check("end_issue_valid", b2.ir_valid, 1'b1);
        check("end_issue_word", b2.ir_out, w_end);
        tick();
`ifdef IFU_PC_WRAP_EN
        check("wrap_fetch_en", b2.imem_rd_en, 1'b1);
        check("wrap_fetch_addr", b2.imem_addr, 8'h00);
        check("wrap_pc_err", err2, 1'b0);
        check("wrap_halted", halted2, 1'b0);
`else
        check("end_halted", halted2, 1'b1);
        check("end_pc_err", err2, 1'b1);
        check("end_pc", pc2, 8'hFF);
        check("end_busy", busy2, 1'b0);
        check("end_rd_en", b2.imem_rd_en, 1'b0);
        // Restart from halt clears the sticky error.
        start2 = 1'b1; tick(); start2 = 1'b0;
        check("end_restart_err", err2, 1'b0);
        check("end_restart_halted", halted2, 1'b0);
        check("end_restart_rd_en", b2.imem_rd_en, 1'b1);
        check("end_restart_pc", pc2, 8'hFF);
`endif

        // Sequential run with ir_ready high: start in cycle 0.
        b1.ir_ready = 1'b1;
        sb.push_back(adi);
        sb.push_back(movi);
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("seq_rd_en_c%0d", c), b1.imem_rd_en, (c == 1 || c == 4 || c == 7));
            check($sformatf("seq_valid_c%0d", c), b1.ir_valid, (c == 3 || c == 6));
            check($sformatf("seq_halted_c%0d", c), halted1, (c == 9));
            if (c == 3) check("seq_word_c3", b1.ir_out, adi);
            if (c == 6) check("seq_word_c6", b1.ir_out, movi);
            if (c < 9) tick();
        end
        check("seq_final_pc", pc1, 8'h02);
        check("seq_final_busy", busy1, 1'b0);

        // Restart from halt.
        b1.ir_ready = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("restart_halted", halted1, 1'b0);
        check("restart_busy", busy1, 1'b1);
        check("restart_rd_en", b1.imem_rd_en, 1'b1);
        check("restart_addr", b1.imem_addr, 8'h00);

        // Table run: backpressure, jumps, and jmp_req noise outside the handshake.
        exp_pc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            mem[exp_pc] = vecs[i].word;
            sb.push_back(vecs[i].word);
            check($sformatf("v%0d_fetch_en", i), b1.imem_rd_en, 1'b1);
            check($sformatf("v%0d_fetch_addr", i), b1.imem_addr, exp_pc);
            b1.ir_ready = 1'b0; b1.jmp_req = 1'b1; b1.jmp_target = 8'hAA;
            tick();
            check($sformatf("v%0d_wait_rd_en", i), b1.imem_rd_en, 1'b0);
            tick();
            for (int s = 0; s < vecs[i].stall; s++) begin
                check($sformatf("v%0d_stall%0d_valid", i, s), b1.ir_valid, 1'b1);
                check($sformatf("v%0d_stall%0d_word", i, s), b1.ir_out, vecs[i].word);
                check($sformatf("v%0d_stall%0d_pc", i, s), pc1, exp_pc);
                check($sformatf("v%0d_stall%0d_rd_en", i, s), b1.imem_rd_en, 1'b0);
                tick();
            end
            check($sformatf("v%0d_issue_valid", i), b1.ir_valid, 1'b1);
            b1.ir_ready = 1'b1; b1.jmp_req = vecs[i].jmp; b1.jmp_target = vecs[i].target;
            tick();
            b1.ir_ready = 1'b0; b1.jmp_req = 1'b0;
            exp_pc = vecs[i].jmp ? vecs[i].target : exp_pc + 8'd1;
        end

        // start while busy is ignored; then reset in ISSUE drops the word.
        check("busy_fetch_addr", b1.imem_addr, exp_pc);
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("busy_start_rd_en", b1.imem_rd_en, 1'b0);
        check("busy_start_pc", pc1, exp_pc);
        tick();
        check("pre_rst_valid", b1.ir_valid, 1'b1);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        check("mid_rst_valid", b1.ir_valid, 1'b0);
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_pc", pc1, 8'h00);
        check("mid_rst_ir_out", b1.ir_out, 32'h0);
        tick();
        check("idle_hold_rd_en", b1.imem_rd_en, 1'b0);
        check("idle_hold_busy", busy1, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
